multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
Next-generation MIPS control unit for the multicycle datapath. It replaces the single-cycle opcode decoder with a Moore FSM that sequences each instruction over 3-5 cycles. It handles a shared instruction/data memory through a ready handshake, and keeps a saturating retired-instruction counter. It sits between the instruction register opcode field and the datapath muxes, register file, ALU control and PC.

Parameters:
OPW, 6, opcode width in bits
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-if-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode (used only with MCU_JUMP_EN)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
OpCode  in  OPW  opcode from instruction register, sampled in DECODE
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU zero (branch)
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  out  1  destination register: 0 = rt, 1 = rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
ALUOp  out  2  00 = add, 01 = sub, 10 = funct decode
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  out  4  current FSM state, for debug
illegal_op  out  1  unknown opcode seen in DECODE
retired  out  CNT_W  count of completed instructions

Behaviour:
- State register updates on the rising edge of clk. rst=1 forces state=FETCH and retired=0 and clears nothing else; all outputs are a Moore decode of state, except where gated by mem_ready as noted.
- Reset mid-instruction aborts the instruction: next state is FETCH, and no count is taken.
- Any control output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - LW/SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP (only when the feature is enabled)
  - anything else -> FETCH, with illegal_op=1 for this cycle only.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for LW, MEMWR for SW (opcode held stable by IR).
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH and retires.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then FETCH and retires on the mem_ready cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH and retires.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH and retires.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH and retires.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH and retires.
- Latency in cycles with mem_ready tied to 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
- Each wait cycle (mem_ready=0) adds one cycle.
- Retire: retired increments by 1 on the clock edge that leaves the final state of an instruction.
- retired saturates at all-ones and never wraps.
- Illegal opcodes do not retire.
- Unused encodings 12-15 go to FETCH on the next edge, with all outputs 0 while in them.
- No output may be X in any state.

Optional Feature:
Macro MCU_JUMP_EN.
- Defined: OP_J is decoded, and the JUMP state is reachable.
- Undefined: the JUMP state logic is omitted; OP_J is treated as illegal (illegal_op pulse, return to FETCH, no retire); PCSource never takes the value 10.

Test Plan:
- rst=1 for 2 cycles, mem_ready=1 -> state=0, retired=0, MemRead=1, ALUSrcB=01, IRWrite=1, PCWrite=1 on the first post-reset cycle.
- R-type (OpCode=000000), mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in cycle 4; retired=1 after 4 cycles.
- LW (100011) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemtoReg=1 in MEMWB; retired +1 after 7 cycles.
- SW (101011) then BEQ (000100), mem_ready=1 -> MemWrite=1, IorD=1 for exactly 1 cycle; PCWriteCond=1 with ALUOp=01 and PCSource=01; retired=2.
- OpCode=111111 -> illegal_op=1 for 1 cycle in DECODE, back to FETCH, retired unchanged. OpCode=000010 -> reaches JUMP with PCSource=10 only with MCU_JUMP_EN, otherwise illegal_op=1.
- CNT_W=2, run 5 ADDI (001000) -> retired goes 1,2,3,3,3; assert rst during ADDIEX -> next state FETCH, retired=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Moore-FSM control unit for a multicycle MIPS datapath. Each instruction is
// sequenced over 3-5 cycles. The shared instruction/data memory is handled
// through the mem_ready handshake. A saturating counter tracks retired
// instructions.
// Optional feature macro: MCU_JUMP_EN. When it is defined, the J opcode is
// decoded and the JUMP state can be reached. When it is undefined, J is
// treated as an illegal opcode.
module multicycle_control_unit #(
    parameter int              OPW      = 6,
    parameter logic [OPW-1:0]  OP_RTYPE = 6'b000000,
    parameter logic [OPW-1:0]  OP_LW    = 6'b100011,
    parameter logic [OPW-1:0]  OP_SW    = 6'b101011,
    parameter logic [OPW-1:0]  OP_BEQ   = 6'b000100,
    parameter logic [OPW-1:0]  OP_ADDI  = 6'b001000,
    parameter logic [OPW-1:0]  OP_J     = 6'b000010,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   OpCode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic             retire_s;
    logic [CNT_W-1:0] retired_r;

    assign state   = state_r;
    assign retired = retired_r;

    // State register: reset aborts any instruction in flight and returns to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Retired-instruction counter: counts on the edge that leaves a final state, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (retire_s && (retired_r != {CNT_W{1'b1}})) begin
            retired_r <= retired_r + CNT_W'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    // Next-state logic and Moore control decode; everything defaults to 0 / FETCH.
    always_comb begin
        next_s      = S_FETCH;
        retire_s    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;

        case (state_r)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    next_s = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (OpCode)
                    OP_LW:    next_s = S_MEMADR;
                    OP_SW:    next_s = S_MEMADR;
                    OP_RTYPE: next_s = S_EXEC;
                    OP_BEQ:   next_s = S_BRANCH;
                    OP_ADDI:  next_s = S_ADDIEX;
`ifdef MCU_JUMP_EN
                    OP_J:     next_s = S_JUMP;
`else
                    OP_J: begin
                        illegal_op = 1'b1;
                        next_s     = S_FETCH;
                    end
`endif
                    default: begin
                        illegal_op = 1'b1;
                        next_s     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // The instruction register holds the opcode stable, so it can be checked again here.
                if (OpCode == OP_SW) begin
                    next_s = S_MEMWR;
                end else begin
                    next_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    next_s = S_MEMWB;
                end else begin
                    next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire_s = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    next_s   = S_FETCH;
                end else begin
                    next_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                next_s  = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire_s    = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next_s  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire_s = 1'b1;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire_s = 1'b1;
            end
`endif
            default: begin
                // Unused encodings return to FETCH with all controls low.
                next_s = S_FETCH;
            end
        endcase
    end

endmodule
